// File: rtl/frame_pkg.sv
// Shared definitions for the 16-bit framed channel link (transmit builder and frame detector).
package frame_pkg;

    localparam logic [31:0] HEADER   = 32'hE0E0E0E0;
    localparam logic [31:0] TRAILER  = 32'h0E0E0E0E;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'h0000;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StHdrHi,
        StHdrLo,
        StChan,
        StData,
        StCrc,
        StTrlHi,
        StTrlLo
    } tx_state_e;

endpackage

// File: rtl/frame_crc16_step.sv
// One 16-bit word of CRC-16/CCITT (MSB first), equivalent to 16 bit-serial shifts.
module frame_crc16_step
    import frame_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);

    // Unrolled bit-serial LFSR over the word, most significant bit first.
    always_comb begin
        logic [15:0] c;
        logic        fb;
        c  = crc_i;
        fb = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data_i[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        crc_o = c;
    end

endmodule

// File: rtl/frame_tx_builder.sv
// Transmit-side frame builder: buffers 1..MAX_WORDS payload words, then emits
// HDR_HI, HDR_LO, CHAN, DATA x N, CRC, TRL_HI, TRL_LO back to back.
// Optional feature: define FRAME_TX_ERR_INJ_EN to add err_inj (inverts the CRC word of a frame).
module frame_tx_builder
    import frame_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned LEN_W     = 4,
    parameter logic [15:0] IDLE_WORD = 16'h0000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_vld,
    output logic             cfg_rdy,
    input  logic [7:0]       cfg_chan,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             cfg_err,
    input  logic             pld_vld,
    output logic             pld_rdy,
    input  logic [15:0]      pld_data,
    output logic [15:0]      data_out,
    output logic             data_out_vld,
    output logic             busy,
    output logic             frame_done
`ifdef FRAME_TX_ERR_INJ_EN
    ,
    input  logic             err_inj
`endif
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS);

    tx_state_e        state_q, state_d;
    logic [7:0]       chan_q, chan_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc_q, crc_d;
    logic             inj_q, inj_d;
    logic             err_q, err_d;
    logic [15:0]      dout_q;
    logic             vld_q, done_q;
    logic [15:0]      buf_q [MAX_WORDS];

    logic             cfg_hs, pld_hs, cfg_bad;
    logic [15:0]      crc_step, crc_word, out_word;
    logic             out_vld;
    logic [IDX_W-1:0] idx;

    // The output stage lags the state by one cycle, so the frame is still in flight while vld_q is set.
    assign busy    = (state_q != StIdle) | vld_q;
    assign cfg_rdy = ~rst & ~busy;
    assign pld_rdy = (state_q == StLoad);
    assign cfg_hs  = cfg_vld & cfg_rdy;
    assign pld_hs  = pld_vld & pld_rdy;
    assign cfg_bad = (cfg_len == '0) || (32'(cfg_len) > MAX_WORDS) || !$onehot(cfg_chan);
    assign idx     = cnt_q[IDX_W-1:0];

    assign cfg_err      = err_q;
    assign data_out     = dout_q;
    assign data_out_vld = vld_q;
    assign frame_done   = done_q;

`ifdef FRAME_TX_ERR_INJ_EN
    assign crc_word = inj_q ? ~crc_q : crc_q;
`else
    assign crc_word = crc_q;
`endif

    frame_crc16_step u_crc (
        .crc_i  (crc_q),
        .data_i (pld_data),
        .crc_o  (crc_step)
    );

    // Next-state: request validation, payload loading and emission sequencing.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        inj_d   = inj_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_hs) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        chan_d  = cfg_chan;
                        len_d   = cfg_len;
                        cnt_d   = '0;
                        crc_d   = CRC_INIT;
`ifdef FRAME_TX_ERR_INJ_EN
                        inj_d   = err_inj;
`else
                        inj_d   = 1'b0;
`endif
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (pld_hs) begin
                    crc_d = crc_step;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        cnt_d   = '0;
                        state_d = StHdrHi;
                    end
                end
            end
            StHdrHi: state_d = StHdrLo;
            StHdrLo: state_d = StChan;
            StChan:  state_d = StData;
            StData: begin
                cnt_d = cnt_q + LEN_W'(1);
                if (cnt_q == len_q - LEN_W'(1)) state_d = StCrc;
            end
            StCrc:   state_d = StTrlHi;
            StTrlHi: state_d = StTrlLo;
            StTrlLo: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Word to place on the bus at the next edge for the current emission state.
    always_comb begin
        out_word = IDLE_WORD;
        out_vld  = 1'b1;
        unique case (state_q)
            StHdrHi: out_word = HEADER[31:16];
            StHdrLo: out_word = HEADER[15:0];
            StChan:  out_word = {8'h00, chan_q};
            StData:  out_word = buf_q[idx];
            StCrc:   out_word = crc_word;
            StTrlHi: out_word = TRAILER[31:16];
            StTrlLo: out_word = TRAILER[15:0];
            default: out_vld  = 1'b0;
        endcase
    end

    // Control state and registered outputs; reset aborts any frame in flight at once.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            chan_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            crc_q   <= CRC_INIT;
            inj_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= IDLE_WORD;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            inj_q   <= inj_d;
            err_q   <= err_d;
            dout_q  <= out_word;
            vld_q   <= out_vld;
            done_q  <= (state_q == StTrlLo);
        end
    end

    // Payload buffer; contents only matter between LOAD and DATA, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (pld_hs) buf_q[idx] <= pld_data;
    end

endmodule
